// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

   localparam int AW_DEF = 5;
   localparam int DW_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // Port 0 = CPU controller, port 1 = display/debug reader.
   typedef logic port_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the port
// that did not win last time is chosen. Purely combinational.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_id_t   last_grant,
   output logic       valid,
   output port_id_t   grant
);

   // Pick the winner from the request vector and the previous grant.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      valid = |req;
      grant = req[1];
      if (req == 2'b11) grant = ~last_grant;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and a display/debug port onto one synchronous-read
// data memory. Each access takes ISSUE (strobe) then RESP (ack/read capture);
// the other port may chain straight from RESP into ISSUE.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
)(
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    req,
   input  logic [1:0]    we,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic [1:0]    ack,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   output logic          mem_re,
   input  logic [DW-1:0] mem_rdata
);

   state_t        r_state;
   port_id_t      r_port;
   port_id_t      r_last_grant;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic          r_we;
   logic [1:0]    r_ack;
   logic          r_mem_we;
   logic          r_mem_re;
   logic [DW-1:0] r_rdata;

   logic [1:0]    w_arb_req;
   logic          w_valid;
   port_id_t      w_grant;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_wdata;
   logic          w_sel_we;

   // In RESP only the port that was not just served may be granted.
   always_comb begin
      w_arb_req = req;
      if (r_state == RESP) begin
         w_arb_req = (r_port == 1'b1) ? {1'b0, req[0]} : {req[1], 1'b0};
      end
   end

   rr_arb2 u_rr_arb2 (
      .req        (w_arb_req),
      .last_grant (r_last_grant),
      .valid      (w_valid),
      .grant      (w_grant)
   );

   // Select the winning port's request fields for latching.
   always_comb begin
      w_sel_addr  = (w_grant == 1'b1) ? addr1  : addr0;
      w_sel_wdata = (w_grant == 1'b1) ? wdata1 : wdata0;
      w_sel_we    = (w_grant == 1'b1) ? we[1]  : we[0];
   end

   // Arbiter FSM with registered strobes, acks and read-data capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_port       <= 1'b0;
         r_last_grant <= 1'b1;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_we         <= 1'b0;
         r_ack        <= 2'b00;
         r_mem_we     <= 1'b0;
         r_mem_re     <= 1'b0;
         r_rdata      <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         r_ack    <= 2'b00;
         r_mem_we <= 1'b0;
         r_mem_re <= 1'b0;
         case (r_state)
            IDLE, RESP: begin
               if (r_state == RESP && !r_we) r_rdata <= mem_rdata;
               if (w_valid) begin
                  r_state      <= ISSUE;
                  r_port       <= w_grant;
                  r_last_grant <= w_grant;
                  r_addr       <= w_sel_addr;
                  r_wdata      <= w_sel_wdata;
                  r_we         <= w_sel_we;
                  r_mem_we     <= w_sel_we;
                  r_mem_re     <= ~w_sel_we;
               end else begin
                  r_state <= IDLE;
               end
            end
            ISSUE: begin
               r_state <= RESP;
               r_ack   <= (r_port == 1'b1) ? 2'b10 : 2'b01;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ack       = r_ack;
   assign rdata     = r_rdata;
   assign busy      = (r_state != IDLE);
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_we    = r_mem_we;
   assign mem_re    = r_mem_re;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus short
// hand-written sequences for round-robin, back-to-back and reset cases.
module tb_mem_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] req, we;
   logic [4:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic [1:0] ack;
   logic [7:0] rdata;
   logic       busy;
   logic [4:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_we, mem_re;
   logic [7:0] mem_rdata;

   logic [7:0] tb_mem [0:31];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(5), .DW(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .we        (we),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .ack       (ack),
      .rdata     (rdata),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata)
   );

   // Synchronous-read memory behind the arbiter.
   always @(posedge clk) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= tb_mem[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0] req;
      logic [1:0] we;
      logic [4:0] a0;
      logic [4:0] a1;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [1:0] ack;
      logic       mwe;
      logic       mre;
      logic       busy;
      logic [4:0] maddr;
      logic [7:0] mwdata;
      logic [7:0] rdata;
   } vec_t;

   vec_t vecs [13];

   initial begin
      // Port 0 write A5 -> 03, port 1 read 03, port 0 read with addr0
      // changed after grant, port 1 write 3C -> 1F.
      vecs[0]  = '{2'b01, 2'b01, 5'h03, 5'h00, 8'hA5, 8'h00, 2'b00, 1'b1, 1'b0, 1'b1, 5'h03, 8'hA5, 8'h00};
      vecs[1]  = '{2'b01, 2'b01, 5'h03, 5'h00, 8'hA5, 8'h00, 2'b01, 1'b0, 1'b0, 1'b1, 5'h03, 8'hA5, 8'h00};
      vecs[2]  = '{2'b00, 2'b00, 5'h03, 5'h00, 8'hA5, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 5'h03, 8'hA5, 8'h00};
      vecs[3]  = '{2'b10, 2'b00, 5'h03, 5'h03, 8'hA5, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1, 5'h03, 8'h00, 8'h00};
      vecs[4]  = '{2'b10, 2'b00, 5'h03, 5'h03, 8'hA5, 8'h00, 2'b10, 1'b0, 1'b0, 1'b1, 5'h03, 8'h00, 8'h00};
      vecs[5]  = '{2'b00, 2'b00, 5'h03, 5'h03, 8'hA5, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 5'h03, 8'h00, 8'hA5};
      vecs[6]  = '{2'b00, 2'b00, 5'h03, 5'h03, 8'hA5, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 5'h03, 8'h00, 8'hA5};
      vecs[7]  = '{2'b01, 2'b00, 5'h03, 5'h03, 8'hA5, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1, 5'h03, 8'hA5, 8'hA5};
      vecs[8]  = '{2'b01, 2'b00, 5'h1F, 5'h03, 8'hA5, 8'h00, 2'b01, 1'b0, 1'b0, 1'b1, 5'h03, 8'hA5, 8'hA5};
      vecs[9]  = '{2'b00, 2'b00, 5'h1F, 5'h03, 8'hA5, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 5'h03, 8'hA5, 8'hA5};
      vecs[10] = '{2'b10, 2'b10, 5'h1F, 5'h1F, 8'hA5, 8'h3C, 2'b00, 1'b1, 1'b0, 1'b1, 5'h1F, 8'h3C, 8'hA5};
      vecs[11] = '{2'b10, 2'b10, 5'h1F, 5'h1F, 8'hA5, 8'h3C, 2'b10, 1'b0, 1'b0, 1'b1, 5'h1F, 8'h3C, 8'hA5};
      vecs[12] = '{2'b00, 2'b00, 5'h1F, 5'h1F, 8'hA5, 8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 5'h1F, 8'h3C, 8'hA5};

      reset = 1'b0;
      req = 2'b00; we = 2'b00;
      addr0 = 5'h00; addr1 = 5'h00;
      wdata0 = 8'h00; wdata1 = 8'h00;

      // Reset state.
      #3;
      check("rst_ack", ack, 2'b00);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_re", mem_re, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_rdata", rdata, 8'h00);
      check("rst_mem_addr", mem_addr, 5'h00);
      check("rst_mem_wdata", mem_wdata, 8'h00);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Table-driven per-cycle vectors.
      for (int i = 0; i < 13; i++) begin
         req = vecs[i].req; we = vecs[i].we;
         addr0 = vecs[i].a0; addr1 = vecs[i].a1;
         wdata0 = vecs[i].d0; wdata1 = vecs[i].d1;
         @(negedge clk);
         check($sformatf("v%0d_ack", i), ack, vecs[i].ack);
         check($sformatf("v%0d_mem_we", i), mem_we, vecs[i].mwe);
         check($sformatf("v%0d_mem_re", i), mem_re, vecs[i].mre);
         check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
         check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].maddr);
         check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].mwdata);
         check($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
      end

      // Round-robin after a fresh reset: both ports reading, grant 0,1,0,1.
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      req = 2'b11; we = 2'b00; addr0 = 5'h03; addr1 = 5'h1F;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("rr%0d_ack", i), ack,
               (i == 1 || i == 5) ? 2'b01 : (i == 3 || i == 7) ? 2'b10 : 2'b00);
         check($sformatf("rr%0d_busy", i), busy, 1'b1);
         if (i % 2 == 0) check($sformatf("rr%0d_mem_addr", i), mem_addr, (i % 4 == 0) ? 5'h03 : 5'h1F);
         if (i == 2) check("rr_rdata_p0", rdata, 8'hA5);
         if (i == 4) check("rr_rdata_p1", rdata, 8'h3C);
      end
      req = 2'b00;
      repeat (2) @(negedge clk);
      check("rr_idle_busy", busy, 1'b0);

      // Port 0 holding req alone: ack every 3 cycles, one idle cycle between.
      req = 2'b01; we = 2'b00; addr0 = 5'h03;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         check($sformatf("b2b%0d_ack", i), ack, (i % 3 == 1) ? 2'b01 : 2'b00);
         check($sformatf("b2b%0d_busy", i), busy, (i % 3 == 2) ? 1'b0 : 1'b1);
         check($sformatf("b2b%0d_mem_re", i), mem_re, (i % 3 == 0) ? 1'b1 : 1'b0);
      end
      req = 2'b00;
      @(negedge clk);

      // Reset during ISSUE of a write aborts it at once with no ack.
      req = 2'b01; we = 2'b01; addr0 = 5'h0A; wdata0 = 8'h77;
      @(posedge clk);
      #1;
      check("abort_pre_mem_we", mem_we, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("abort_mem_we", mem_we, 1'b0);
      check("abort_mem_re", mem_re, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_ack", ack, 2'b00);
      req = 2'b00; we = 2'b00;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("abort_hold%0d_ack", i), ack, 2'b00);
      end
      reset = 1'b1;
      @(negedge clk);
      check("abort_idle_busy", busy, 1'b0);
      check("abort_idle_ack", ack, 2'b00);
      req = 2'b11; addr0 = 5'h03; addr1 = 5'h1F;
      @(negedge clk);
      check("tie_mem_addr", mem_addr, 5'h03);
      check("tie_mem_re", mem_re, 1'b1);
      @(negedge clk);
      check("tie_ack", ack, 2'b01);
      req = 2'b00;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 5, address width of the shared data memory.
REQ-002 Parameter DW, 8, data width of the shared data memory.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  2  per-port request level; bit 0 = CPU controller port, bit 1 = display/debug reader port.
REQ-006 we  input  2  per-port write select; 1 = write, 0 = read.
REQ-007 addr0, addr1  input  AW each  per-port word address.
REQ-008 wdata0, wdata1  input  DW each  per-port write data.
REQ-009 ack  output  2  per-port one-cycle completion pulse.
REQ-010 rdata  output  DW  read data of the most recently completed read.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 mem_addr  output  AW  address to memory.
REQ-013 mem_wdata  output  DW  write data to memory.
REQ-014 mem_we, mem_re  output  1 each  memory write/read strobes.
REQ-015 mem_rdata  input  DW  memory read data, valid one cycle after mem_re (synchronous read).

Function
REQ-016 FSM states SHALL be IDLE, ISSUE and RESP; any unencoded state SHALL go to IDLE on the next edge.
REQ-017 IDLE: if any req bit is high at an edge, the arbiter SHALL go to ISSUE and latch the granted port id, its addr, wdata and we; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be two-way round-robin: a single requester wins; with both requesting, the port other than last_grant wins; last_grant updates to the winner at the grant edge.
REQ-019 ISSUE (exactly one cycle): mem_addr/mem_wdata SHALL come from the latched values; mem_we = latched we; mem_re = not latched we; next state RESP.
REQ-020 Outside ISSUE, mem_we and mem_re SHALL be 0; mem_addr and mem_wdata SHALL hold the latched values.
REQ-021 RESP (exactly one cycle): ack of the latched port SHALL be 1; for a read, rdata SHALL load mem_rdata at the RESP-ending edge and hold it until the next read completes.
REQ-022 RESP exit: if the non-acked port requests, the arbiter SHALL grant it and go directly to ISSUE (latching as in REQ-017); otherwise it SHALL go to IDLE. The acked port's req SHALL be ignored in RESP.
REQ-023 Latency: with req sampled high at edge k, ISSUE spans k..k+1, ack is high in k+1..k+2, and read data is visible on rdata from k+2.
REQ-024 addr/wdata/we changes after the grant edge SHALL NOT affect the transaction in flight.
REQ-025 Sustained single-port throughput SHALL be one transaction per 3 cycles; alternating two-port throughput SHALL be one per 2 cycles.
REQ-026 At most one ack bit SHALL be high in any cycle; ack SHALL be 0 outside RESP.
REQ-027 A requester SHALL keep req high until its ack; dropping req before ack SHALL NOT cancel a latched transaction.

Reset
REQ-028 reset low SHALL immediately force state to IDLE, with ack = 0, mem_we = 0, mem_re = 0 and busy = 0.
REQ-029 While reset is low: rdata = 0, latched addr/wdata = 0, latched we = 0, and last_grant = 1, so port 0 wins the first tie.
REQ-030 Reset asserted during ISSUE SHALL abort the memory access combinationally; no ack SHALL be issued for it.

Structure
REQ-031 A shared package mem_arb_pkg SHALL hold the state enum (IDLE, ISSUE, RESP), the port-id type and the AW/DW defaults.
REQ-032 The round-robin pick SHALL be a sub-module rr_arb2, inputs req[1:0] and last_grant, outputs valid and grant id, purely combinational.

Verification
REQ-033 Port 0 writes 8'hA5 to address 5'h03 -> mem_we is high for exactly one cycle with mem_addr = 03 and mem_wdata = A5; ack[0] pulses one cycle later.
REQ-034 Port 1 reads address 03 after REQ-033 -> mem_re pulses once, ack[1] pulses, and rdata = A5 from the following cycle onward.
REQ-035 Both ports request from IDLE after reset -> grant order 0,1,0,1 with acks on alternating ports every 2 cycles.
REQ-036 Port 0 holds req continuously with port 1 idle -> ack[0] every 3 cycles and busy drops to 0 for one cycle between transactions.
REQ-037 reset pulled low during ISSUE of a write -> mem_we drops in the same cycle, no ack appears, and after release the FSM is in IDLE with port 0 winning the first tie.
REQ-038 addr0 is changed from 03 to 1F the cycle after the grant edge -> mem_addr stays at 03 for that transaction.
